// File: rtl/sia_txq_if.sv
// Host write port of the SIA transmit queue: write strobe/data in, FIFO status out.
interface sia_txq_if #(
  parameter int unsigned DATA_BITS = 12
);
  logic                 txq_we_i;
  logic [DATA_BITS-1:0] txq_dat_i;
  logic                 txq_full_o;
  logic                 txq_empty_o;

  modport master (output txq_we_i, txq_dat_i, input txq_full_o, txq_empty_o);
  modport slave  (input txq_we_i, txq_dat_i, output txq_full_o, txq_empty_o);
endinterface

// File: rtl/sia_txq.sv
// SIA transmitter: small FIFO feeding an LSB-first shifter with programmable bit time.
// Optional break generation is enabled by defining SIA_TXQ_BREAK_EN (adds txbrk_i).
module sia_txq #(
  parameter int unsigned SHIFT_REG_WIDTH = 12,
  parameter int unsigned BAUD_RATE_WIDTH = 32,
  parameter int unsigned DEPTH_BITS      = 2,
  parameter int unsigned DATA_BITS       = 12
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic [4:0]                 bits_i,
  input  logic [BAUD_RATE_WIDTH-1:0] baud_i,
  input  logic                       txcpol_i,
`ifdef SIA_TXQ_BREAK_EN
  input  logic                       txbrk_i,
`endif
  sia_txq_if.slave                   txq,
  output logic                       idle_o,
  output logic                       txd_o,
  output logic                       txc_o
);

  localparam int unsigned DEPTH = 1 << DEPTH_BITS;

  typedef enum logic {ST_IDLE, ST_SHIFT} state_e;

  state_e                       state_q, state_d;
  logic [DEPTH_BITS:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DATA_BITS-1:0]         mem_q [DEPTH];
  logic [SHIFT_REG_WIDTH-1:0]   sh_q, sh_d;
  logic [4:0]                   bitcnt_q, bitcnt_d;
  logic [BAUD_RATE_WIDTH-1:0]   baudcnt_q, baudcnt_d, baud_q, baud_d;
  logic                         txcpol_q, txcpol_d;
  logic                         phase_q, phase_d;
  logic                         txd_q, txd_d;
  logic                         idle_q, idle_d;
  logic                         empty, full, push, pop, load, can_launch;
  logic [DATA_BITS-1:0]         head;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[DEPTH_BITS-1:0] == rd_ptr_q[DEPTH_BITS-1:0]) &&
                 (wr_ptr_q[DEPTH_BITS] != rd_ptr_q[DEPTH_BITS]);
  assign push  = txq.txq_we_i && !full;
  assign head  = mem_q[rd_ptr_q[DEPTH_BITS-1:0]];

`ifdef SIA_TXQ_BREAK_EN
  // brk_q delays launch by one edge after release so the line shows mark first.
  logic brk_q, brk_d;
  assign brk_d      = txbrk_i;
  assign can_launch = !txbrk_i && !brk_q;
`else
  assign can_launch = 1'b1;
`endif

  always_comb begin
    state_d   = state_q;
    sh_d      = sh_q;
    bitcnt_d  = bitcnt_q;
    baudcnt_d = baudcnt_q;
    baud_d    = baud_q;
    txcpol_d  = txcpol_q;
    pop       = 1'b0;
    load      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!empty && can_launch) begin
          pop  = 1'b1;
          load = (bits_i != '0);
        end
      end
      ST_SHIFT: begin
        if (baudcnt_q == '0) begin
          sh_d      = {1'b1, sh_q[SHIFT_REG_WIDTH-1:1]};
          bitcnt_d  = bitcnt_q - 5'd1;
          baudcnt_d = baud_q;
          if (bitcnt_q == 5'd1) begin
            // Last bit time ends: chain straight into the next entry if one is ready.
            state_d = ST_IDLE;
            if (!empty && can_launch) begin
              pop  = 1'b1;
              load = (bits_i != '0);
            end
          end
        end else begin
          baudcnt_d = baudcnt_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (load) begin
      state_d                 = ST_SHIFT;
      sh_d                    = '1;
      sh_d[DATA_BITS-1:0]     = head;
      bitcnt_d                = bits_i;
      baudcnt_d               = baud_i;
      baud_d                  = baud_i;
      txcpol_d                = txcpol_i;
    end

    wr_ptr_d = wr_ptr_q + {{DEPTH_BITS{1'b0}}, push};
    rd_ptr_d = rd_ptr_q + {{DEPTH_BITS{1'b0}}, pop};

    txd_d = (state_d == ST_SHIFT) ? sh_d[0] : 1'b1;
`ifdef SIA_TXQ_BREAK_EN
    if (state_d == ST_IDLE && txbrk_i) txd_d = 1'b0;
`endif
    phase_d = (state_d == ST_SHIFT) && (baudcnt_d <= (baud_d >> 1));
    idle_d  = (state_d == ST_IDLE) && (wr_ptr_d == rd_ptr_d);
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q   <= ST_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      sh_q      <= '0;
      bitcnt_q  <= '0;
      baudcnt_q <= '0;
      baud_q    <= '0;
      txcpol_q  <= 1'b0;
      phase_q   <= 1'b0;
      txd_q     <= 1'b1;
      idle_q    <= 1'b1;
`ifdef SIA_TXQ_BREAK_EN
      brk_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      sh_q      <= sh_d;
      bitcnt_q  <= bitcnt_d;
      baudcnt_q <= baudcnt_d;
      baud_q    <= baud_d;
      txcpol_q  <= txcpol_d;
      phase_q   <= phase_d;
      txd_q     <= txd_d;
      idle_q    <= idle_d;
`ifdef SIA_TXQ_BREAK_EN
      brk_q     <= brk_d;
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q[DEPTH_BITS-1:0]] <= txq.txq_dat_i;
  end

  assign txq.txq_full_o  = full;
  assign txq.txq_empty_o = empty;
  assign idle_o          = idle_q;
  assign txd_o           = txd_q;
  // Polarity is frozen for the frame in flight; the live input shows while idle.
  assign txc_o           = ((state_q == ST_SHIFT) ? txcpol_q : txcpol_i) ^ phase_q;

endmodule

// File: doc/sia_txq.md
# sia_txq

Transmit half of the Serial Interface Adapter (SIA). The block accepts pre-framed words from the host bus into a small FIFO and shifts each word out LSB-first on `txd_o`, one bit per programmable bit time. It also drives a companion bit clock on `txc_o`. It is the counterpart of `sia_rxq`, uses the same frame format and baud convention, and a looped-back `txd_o` reproduces the words written.

## Interface
- `SHIFT_REG_WIDTH`, 12, output shift register width.
- `BAUD_RATE_WIDTH`, 32, width of `baud_i` and the bit-time counter.
- `DEPTH_BITS`, 2, FIFO holds 2^DEPTH_BITS entries.
- `DATA_BITS`, 12, FIFO entry width (≤ SHIFT_REG_WIDTH).

- `clk_i`  in  1  single clock; all state changes on rising edge.
- `reset_i`  in  1  synchronous, active-low reset.
- `bits_i`  in  5  bit times per frame (start + data + parity + stop, as framed by host).
- `baud_i`  in  BAUD_RATE_WIDTH  bit time minus one, in clocks.
- `txcpol_i`  in  1  idle level / polarity of `txc_o`.
- `txq_we_i`  in  1  write strobe; push `txq_dat_i` when not full.
- `txq_dat_i`  in  DATA_BITS  frame word, bit 0 sent first.
- `txq_full_o`  out  1  FIFO full.
- `txq_empty_o`  out  1  FIFO empty.
- `idle_o`  out  1  no frame in progress and FIFO empty.
- `txd_o`  out  1  serial data; idle (mark) = 1.
- `txc_o`  out  1  serial bit clock.

## Operation
- FIFO: read/write pointers DEPTH_BITS+1 wide. Empty means pointers are equal. Full means the index bits are equal and the MSBs differ.
- Write while `txq_full_o`=1 is dropped, even if a pop happens in the same cycle. Writes and pops otherwise proceed simultaneously.
- FSM states:
  - IDLE: `txd_o`=1. If the FIFO is not empty: pop, load the shifter, load the bit counter with `bits_i`, load the baud counter with `baud_i`, then go to SHIFT.
  - SHIFT: `txd_o` = shifter bit 0. The baud counter decrements each clock. At 0 it does the following:
    - Shift right with 1-fill.
    - Decrement the bit counter.
    - Reload `baud_i`.
  - End of frame: when the bit counter reaches 0, load the next entry in the same edge if the FIFO is not empty (no gap). Otherwise go to IDLE.
- Shifter load: entry in bits [DATA_BITS-1:0], upper bits set to 1. If `bits_i` > SHIFT_REG_WIDTH, the excess bit times send 1.
- `bits_i`=0: the entry is popped and discarded, nothing is sent, and the FSM stays in IDLE.
- `baud_i`, `bits_i` and `txcpol_i` are sampled only at frame load. Changes take effect at the next frame.
- `txc_o` = `txcpol_i` XOR phase. phase=1 in SHIFT when baud counter ≤ (`baud_i`>>1). phase=0 otherwise. The active edge is mid-bit.
- Reset (`reset_i`=0 at an edge) has priority over everything:
  - Pointers, counters and shifter are cleared.
  - FSM goes to IDLE.
  - A frame in progress is aborted.

## Timing
- After reset: `txd_o`=1, `txc_o`=`txcpol_i`, `txq_full_o`=0, `txq_empty_o`=1, `idle_o`=1.
- Write at edge N makes `txq_empty_o`=0 after N.
- When idle, the pop and load occur at edge N+1. The start bit appears on `txd_o` after N+1.
- Each bit lasts exactly `baud_i`+1 clocks. A frame lasts `bits_i`×(`baud_i`+1) clocks.
- `idle_o` rises in the cycle after the last bit time ends with the FIFO empty.
- All outputs except `txc_o` are registered. `txc_o` is combinational from the phase register and `txcpol_i`.

## Configuration
- `SIA_TXQ_BREAK_EN` defined: adds input `txbrk_i` (1 bit).
  - While `txbrk_i`=1 in IDLE, `txd_o`=0 and no frame is launched.
  - A frame in progress completes first.
  - Releasing `txbrk_i` returns `txd_o` to 1 on the next edge. Frame launch resumes on the edge after that.
- `SIA_TXQ_BREAK_EN` undefined: no port, and break behaviour is absent.

## Test plan
- Reset with `txcpol_i`=0 -> `txd_o`=1, `txc_o`=0, empty=1, full=0, idle=1.
- `baud_i`=49, `bits_i`=10, write 10'b1_10100001_0 -> `txd_o` sequence 0,1,0,0,0,0,1,0,1,1, each bit 50 clocks. `txc_o` rises 25 clocks into each bit. idle=1 afterwards.
- Four writes back to back while idle -> the first pops immediately, full stays 0. A fifth write lands and full=1. A sixth is dropped. Exactly five frames are sent with no inter-frame gap.
- Write with `bits_i`=0 followed by 10'b1_01010101_0 with `bits_i`=10 -> only the second frame appears on the line.
- Reset asserted mid-frame at bit 4 -> `txd_o`=1 next cycle, empty=1. Pending entries are lost.
- With `SIA_TXQ_BREAK_EN`: hold `txbrk_i`=1, write a word -> `txd_o`=0 and the entry is held. Release -> the frame starts 2 edges later.
